// File: rtl/ysyx_25060170_pkg.sv
// Shared definitions for the ysyx_25060170 core: IFU state encoding, instruction
// width and the reset PC that the simulator's difftest also starts from.
package ysyx_25060170_pkg;

   localparam int          INST_W           = 32;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;

   typedef enum logic [2:0] {
      IFU_IDLE        = 3'd0,
      IFU_REQ         = 3'd1,
      IFU_RSP         = 3'd2,
      IFU_ISSUE       = 3'd3,
      IFU_WAIT_COMMIT = 3'd4,
      IFU_TRAP        = 3'd5
   } ifu_state_e;

endpackage

// File: rtl/ysyx_25060170_ifu.sv
// Instruction fetch unit: one instruction in flight, refetch only after WBU commit.
// Define YSYX_25060170_IFU_MISALIGN_CHK_EN to trap on a misaligned PC load.
module ysyx_25060170_ifu
   import ysyx_25060170_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic              clk,
   input  logic              rst,
   output logic              imem_req_valid_o,
   output logic [31:0]       imem_req_addr_o,
   input  logic              imem_req_ready_i,
   input  logic              imem_rsp_valid_i,
   input  logic [INST_W-1:0] imem_rsp_data_i,
   output logic              imem_rsp_ready_o,
   output logic [31:0]       pc_o,
   output logic [INST_W-1:0] inst_o,
   output logic              inst_valid_o,
   input  logic              IDU_ready_i,
   input  logic              commit_valid_i,
   input  logic [31:0]       commit_pc_i,
`ifdef YSYX_25060170_IFU_MISALIGN_CHK_EN
   output logic              misalign_o,
`endif
   output logic [63:0]       inst_cnt_o
);

   ifu_state_e        state, state_n, load_state;
   logic [31:0]       pc, pc_n;
   logic [INST_W-1:0] inst, inst_n;
   logic [63:0]       cnt, cnt_n;

   // Where a PC load (reset PC in IDLE, otherwise a commit) sends the FSM.
`ifdef YSYX_25060170_IFU_MISALIGN_CHK_EN
   logic [31:0] load_pc;
   assign load_pc    = (state == IFU_IDLE) ? pc : commit_pc_i;
   assign load_state = (load_pc[1:0] != 2'b00) ? IFU_TRAP : IFU_REQ;
`else
   assign load_state = IFU_REQ;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IFU_IDLE;
         pc    <= RESET_PC;
         inst  <= '0;
         cnt   <= '0;
      end else begin
         state <= state_n;
         pc    <= pc_n;
         inst  <= inst_n;
         cnt   <= cnt_n;
      end
   end

   always_comb begin
      state_n = state;
      pc_n    = pc;
      inst_n  = inst;
      cnt_n   = cnt;
      unique case (state)
         IFU_IDLE: state_n = load_state;
         IFU_REQ: if (imem_req_ready_i) state_n = IFU_RSP;
         IFU_RSP: if (imem_rsp_valid_i) begin
            inst_n  = imem_rsp_data_i;
            state_n = IFU_ISSUE;
         end
         IFU_ISSUE: if (IDU_ready_i) begin
            cnt_n = cnt + 64'd1;
            // A commit landing with the handshake skips WAIT_COMMIT entirely.
            if (commit_valid_i) begin
               pc_n    = commit_pc_i;
               state_n = load_state;
            end else begin
               state_n = IFU_WAIT_COMMIT;
            end
         end
         IFU_WAIT_COMMIT: if (commit_valid_i) begin
            pc_n    = commit_pc_i;
            state_n = load_state;
         end
         IFU_TRAP: state_n = IFU_TRAP;
         default:  state_n = IFU_IDLE;
      endcase
   end

   assign imem_req_valid_o = (state == IFU_REQ);
   assign imem_req_addr_o  = {pc[31:2], 2'b00};
   assign imem_rsp_ready_o = (state == IFU_RSP);
   assign inst_valid_o     = (state == IFU_ISSUE);
   assign pc_o             = pc;
   assign inst_o           = inst;
   assign inst_cnt_o       = cnt;
`ifdef YSYX_25060170_IFU_MISALIGN_CHK_EN
   assign misalign_o       = (state == IFU_TRAP);
`endif

endmodule
